// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA raster generator.
//   - default 640x480@60 horizontal/vertical timing and pixel divider
//   - derived line/frame totals and sync window bounds
//   - cnt_t: 10-bit raster coordinate type used by all layer sources
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;

    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned PIX_DIV_DEF  = 4;

    localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int unsigned H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
    localparam int unsigned V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

    // Half-open window test done at 32 bits so a window ending at 1024 still decodes.
    function automatic logic in_span(cnt_t v, int unsigned lo, int unsigned hi);
        return (32'(v) >= lo) && (32'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster bus from the timing generator to the renderer and layer sources.
//   pix_tick     1-clk pulse at the end of each pixel period
//   h_cnt/v_cnt  current pixel column / line
//   valid        pixel lies in the visible area
//   hsync/vsync  sync outputs, already at the configured polarity
//   line_start   1-clk pulse in the first clk of each line
//   frame_start  1-clk pulse in the first clk of each frame
// master: the timing generator; slave: any consumer.
interface vga_timing_if;
    import vga_timing_pkg::*;

    logic pix_tick;
    cnt_t h_cnt;
    cnt_t v_cnt;
    logic valid;
    logic hsync;
    logic vsync;
    logic line_start;
    logic frame_start;

    modport master (
        output pix_tick, h_cnt, v_cnt, valid, hsync, vsync, line_start, frame_start
    );

    modport slave (
        input pix_tick, h_cnt, v_cnt, valid, hsync, vsync, line_start, frame_start
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrap counter over COUNT_ACTIVE+FP+SYNC+BP positions.
//   clk, rst_n    clock, async active-low reset (counter resets to its last position)
//   inc           advance by one this clk
//   cnt           current position
//   wrap_out      inc while at the last position (counter returns to 0 next)
//   active_next   next position lies in the active region
//   sync_next     next position lies in the sync window (polarity-free)
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned COUNT_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned FP           = H_FP_DEF,
    parameter int unsigned SYNC         = H_SYNC_DEF,
    parameter int unsigned BP           = H_BP_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    output cnt_t cnt,
    output logic wrap_out,
    output logic active_next,
    output logic sync_next
);

    localparam int unsigned TOTAL      = COUNT_ACTIVE + FP + SYNC + BP;
    localparam cnt_t        LAST       = cnt_t'(TOTAL - 1);
    localparam int unsigned SYNC_START = COUNT_ACTIVE + FP;
    localparam int unsigned SYNC_END   = SYNC_START + SYNC;

    cnt_t cnt_q;
    cnt_t cnt_d;

    always_comb begin
        wrap_out = inc && (cnt_q == LAST);
        if (wrap_out) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + cnt_t'(1);
        end else begin
            cnt_d = cnt_q;
        end
        // Decoded from the next value so the registered flags line up with cnt.
        active_next = 32'(cnt_d) < COUNT_ACTIVE;
        sync_next   = in_span(cnt_d, SYNC_START, SYNC_END);
    end

    // Resetting to the last position makes the first advance land on 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= LAST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (default 640x480@60 from a 100 MHz clock).
//   clk     system clock
//   rst_n   async active-low reset
//   vga     raster bus (master): pix_tick, h_cnt, v_cnt, valid, hsync, vsync,
//           line_start, frame_start
// Holds the pixel divider, sync polarity and the line/frame strobe registers; the
// two axis counters are chained so the vertical stage advances on the horizontal wrap.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned PIX_DIV  = PIX_DIV_DEF,
    parameter bit          SYNC_POL = 1'b0
) (
    input logic         clk,
    input logic         rst_n,
    vga_timing_if.master vga
);

    localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    typedef logic [DIV_W-1:0] div_t;
    localparam div_t DIV_LAST = div_t'(PIX_DIV - 1);

    div_t div_q;
    div_t div_d;
    logic pix_tick;

    cnt_t h_cnt;
    cnt_t v_cnt;
    logic h_wrap;
    logic v_wrap;
    logic h_active_next;
    logic v_active_next;
    logic h_sync_next;
    logic v_sync_next;

    logic valid_q;
    logic valid_d;
    logic hsync_q;
    logic hsync_d;
    logic vsync_q;
    logic vsync_d;
    logic line_start_q;
    logic frame_start_q;

    always_comb begin
        // Gated by rst_n so a PIX_DIV=1 build reports no tick while held in reset.
        pix_tick = rst_n && (div_q == DIV_LAST);
        div_d    = pix_tick ? '0 : div_q + div_t'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    vga_axis_counter #(
        .COUNT_ACTIVE (H_ACTIVE),
        .FP           (H_FP),
        .SYNC         (H_SYNC),
        .BP           (H_BP)
    ) u_h_axis (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc         (pix_tick),
        .cnt         (h_cnt),
        .wrap_out    (h_wrap),
        .active_next (h_active_next),
        .sync_next   (h_sync_next)
    );

    vga_axis_counter #(
        .COUNT_ACTIVE (V_ACTIVE),
        .FP           (V_FP),
        .SYNC         (V_SYNC),
        .BP           (V_BP)
    ) u_v_axis (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc         (h_wrap),
        .cnt         (v_cnt),
        .wrap_out    (v_wrap),
        .active_next (v_active_next),
        .sync_next   (v_sync_next)
    );

    always_comb begin
        valid_d = h_active_next && v_active_next;
        hsync_d = h_sync_next ? SYNC_POL : ~SYNC_POL;
        vsync_d = v_sync_next ? SYNC_POL : ~SYNC_POL;
    end

    // Strobes capture the wrap itself, so they are high in the first clk at h_cnt==0.
    // v_wrap already implies h_wrap, so frame_start coincides with a line_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
        end
    end

    assign vga.pix_tick    = pix_tick;
    assign vga.h_cnt       = h_cnt;
    assign vga.v_cnt       = v_cnt;
    assign vga.valid       = valid_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with three builds:
//   dut_a: default 640x480 timing, PIX_DIV=4, SYNC_POL=0
//   dut_b: default horizontal, 10-line frame (6/1/2/1), PIX_DIV=1, SYNC_POL=1
//   dut_c: 15x10 raster (8/2/3/2, 6/1/2/1), PIX_DIV=4, SYNC_POL=0
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_timing_if if_a ();
    vga_timing_if if_b ();
    vga_timing_if if_c ();

    vga_timing_gen #(
        .PIX_DIV  (4),
        .SYNC_POL (1'b0)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (if_a)
    );

    vga_timing_gen #(
        .V_ACTIVE (6),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .PIX_DIV  (1),
        .SYNC_POL (1'b1)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (if_b)
    );

    vga_timing_gen #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (2),
        .V_ACTIVE (6),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .PIX_DIV  (4),
        .SYNC_POL (1'b0)
    ) dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (if_c)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Raster invariants, sampled on the falling edge while out of reset.
    always @(negedge clk) begin : inv_chk
        int ha, va, hb, vb, hc, vc;
        ha = int'(if_a.h_cnt);
        va = int'(if_a.v_cnt);
        hb = int'(if_b.h_cnt);
        vb = int'(if_b.v_cnt);
        hc = int'(if_c.h_cnt);
        vc = int'(if_c.v_cnt);
        if (rst_n) begin
            check("a_valid_inv", int'(if_a.valid), int'(ha < 640 && va < 480));
            check("a_hsync_inv", int'(if_a.hsync), int'(!(ha >= 656 && ha < 752)));
            check("a_vsync_inv", int'(if_a.vsync), int'(!(va >= 490 && va < 492)));
            check("a_range", int'(ha <= 799 && va <= 524), 1);
            check("b_pix_tick", int'(if_b.pix_tick), 1);
            check("b_valid_inv", int'(if_b.valid), int'(hb < 640 && vb < 6));
            check("b_hsync_inv", int'(if_b.hsync), int'(hb >= 656 && hb < 752));
            check("b_vsync_inv", int'(if_b.vsync), int'(vb >= 7 && vb < 9));
            check("b_range", int'(hb <= 799 && vb <= 9), 1);
            check("c_valid_inv", int'(if_c.valid), int'(hc < 8 && vc < 6));
            check("c_hsync_inv", int'(if_c.hsync), int'(!(hc >= 10 && hc < 13)));
            check("c_vsync_inv", int'(if_c.vsync), int'(!(vc >= 7 && vc < 9)));
            check("c_range", int'(hc <= 14 && vc <= 9), 1);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_h"}, int'(if_a.h_cnt), 799);
        check({tag, "_a_v"}, int'(if_a.v_cnt), 524);
        check({tag, "_a_valid"}, int'(if_a.valid), 0);
        check({tag, "_a_hsync"}, int'(if_a.hsync), 1);
        check({tag, "_a_vsync"}, int'(if_a.vsync), 1);
        check({tag, "_a_tick"}, int'(if_a.pix_tick), 0);
        check({tag, "_a_ls"}, int'(if_a.line_start), 0);
        check({tag, "_a_fs"}, int'(if_a.frame_start), 0);
        check({tag, "_b_tick"}, int'(if_b.pix_tick), 0);
        check({tag, "_b_hsync"}, int'(if_b.hsync), 0);
        check({tag, "_b_h"}, int'(if_b.h_cnt), 799);
        check({tag, "_c_h"}, int'(if_c.h_cnt), 14);
        check({tag, "_c_v"}, int'(if_c.v_cnt), 9);
    endtask

    // Release reset and check the first PIX_DIV clks of the raster.
    task automatic release_and_check(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check({tag, "_hold_h"}, int'(if_a.h_cnt), 799);
            check({tag, "_hold_v"}, int'(if_a.v_cnt), 524);
            check({tag, "_hold_valid"}, int'(if_a.valid), 0);
            check({tag, "_hold_hsync"}, int'(if_a.hsync), 1);
            check({tag, "_hold_fs"}, int'(if_a.frame_start), 0);
            if (i == 1) begin
                check({tag, "_b_first_h"}, int'(if_b.h_cnt), 0);
                check({tag, "_b_first_v"}, int'(if_b.v_cnt), 0);
                check({tag, "_b_first_fs"}, int'(if_b.frame_start), 1);
                check({tag, "_b_first_ls"}, int'(if_b.line_start), 1);
            end
        end
        @(negedge clk);
        check({tag, "_first_h"}, int'(if_a.h_cnt), 0);
        check({tag, "_first_v"}, int'(if_a.v_cnt), 0);
        check({tag, "_first_valid"}, int'(if_a.valid), 1);
        check({tag, "_first_fs"}, int'(if_a.frame_start), 1);
        check({tag, "_first_ls"}, int'(if_a.line_start), 1);
        check({tag, "_c_first_h"}, int'(if_c.h_cnt), 0);
        check({tag, "_c_first_fs"}, int'(if_c.frame_start), 1);
        @(negedge clk);
        check({tag, "_fs_drop"}, int'(if_a.frame_start), 0);
        check({tag, "_ls_drop"}, int'(if_a.line_start), 0);
        check({tag, "_h_still0"}, int'(if_a.h_cnt), 0);
    endtask

    initial begin
        int n, lo, t0, cnt_v, cnt_h, cnt_ls, cnt_fs;

        // Reset values
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        release_and_check("rel");

        // hsync pulse width and line period on dut_a
        n = 0;
        while (if_a.hsync !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("a_hs_fall1_found", int'(n < 4000), 1);
        check("a_hs_fall1_h", int'(if_a.h_cnt), 656);
        check("a_hs_fall1_v", int'(if_a.v_cnt), 0);
        t0 = cyc;
        lo = 0;
        while (if_a.hsync === 1'b0 && lo < 1000) begin
            @(negedge clk);
            lo++;
        end
        check("a_hs_low_clks", lo, 384);
        check("a_hs_rise_h", int'(if_a.h_cnt), 752);
        n = 0;
        while (if_a.hsync !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("a_hs_fall2_found", int'(n < 4000), 1);
        check("a_hs_period", cyc - t0, 3200);
        check("a_hs_fall2_h", int'(if_a.h_cnt), 656);
        check("a_hs_fall2_v", int'(if_a.v_cnt), 1);

        // Line wrap and visible pixel count over one full line
        n = 0;
        while (if_a.line_start !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("a_ls_found", int'(n < 4000), 1);
        check("a_ls_h", int'(if_a.h_cnt), 0);
        check("a_ls_v", int'(if_a.v_cnt), 2);
        cnt_v = 0;
        cnt_ls = 0;
        for (int i = 0; i < 3200; i++) begin
            if (if_a.valid) cnt_v++;
            if (if_a.line_start) cnt_ls++;
            @(negedge clk);
        end
        check("a_line_valid_clks", cnt_v, 2560);
        check("a_line_ls_pulses", cnt_ls, 1);
        check("a_ls_next", int'(if_a.line_start), 1);
        check("a_ls_next_v", int'(if_a.v_cnt), 3);
        check("a_ls_next_h", int'(if_a.h_cnt), 0);

        // Asynchronous reset mid-line
        n = 0;
        while (int'(if_a.h_cnt) != 300 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("a_h300_found", int'(n < 2000), 1);
        check("a_h300_valid", int'(if_a.valid), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        repeat (2) @(negedge clk);
        release_and_check("rel2");

        // Frame wrap on the small raster
        n = 0;
        while (if_c.frame_start !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("c_fs_found", int'(n < 1000), 1);
        n = 0;
        cnt_v = 0;
        cnt_ls = 0;
        cnt_fs = 0;
        do begin
            if (!if_c.vsync) cnt_v++;
            if (if_c.line_start) cnt_ls++;
            if (if_c.frame_start) cnt_fs++;
            @(negedge clk);
            n++;
        end while (if_c.frame_start !== 1'b1 && n < 1000);
        check("c_frame_clks", n, 600);
        check("c_vsync_low_clks", cnt_v, 120);
        check("c_line_starts", cnt_ls, 10);
        check("c_frame_starts", cnt_fs, 1);
        check("c_wrap_h", int'(if_c.h_cnt), 0);
        check("c_wrap_v", int'(if_c.v_cnt), 0);

        // PIX_DIV=1, positive sync polarity
        n = 0;
        while (if_b.frame_start !== 1'b1 && n < 9000) begin
            @(negedge clk);
            n++;
        end
        check("b_fs_found", int'(n < 9000), 1);
        n = 0;
        cnt_h = 0;
        cnt_v = 0;
        cnt_ls = 0;
        cnt_fs = 0;
        do begin
            if (if_b.hsync) cnt_h++;
            if (if_b.vsync) cnt_v++;
            if (if_b.line_start) cnt_ls++;
            if (if_b.frame_start) cnt_fs++;
            @(negedge clk);
            n++;
        end while (if_b.frame_start !== 1'b1 && n < 9000);
        check("b_frame_clks", n, 8000);
        check("b_hsync_high_clks", cnt_h, 960);
        check("b_vsync_high_clks", cnt_v, 1600);
        check("b_line_starts", cnt_ls, 10);
        check("b_frame_starts", cnt_fs, 1);
        n = 0;
        while (if_b.hsync !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("b_hs_rise_found", int'(n < 1000), 1);
        check("b_hs_rise_h", int'(if_b.h_cnt), 656);
        check("b_hs_rise_clks", n, 656);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
